// File: rtl/hex_tx_sequencer.sv
// hex_tx_sequencer: prints a binary word as uppercase hex ASCII, most
// significant nibble first, over a valid/ready byte interface to UART TX.
// Optional macro HEX_TX_SEQUENCER_CRLF_EN appends CR (0x0D) and LF (0x0A)
// after the digits of every word.
// Also contains dec2assic, the 4-bit-to-ASCII hex digit converter.

module dec2assic (
   input  logic [3:0] nib,
   output logic [7:0] ascii
);

   // 0..9 map to '0'..'9', 10..15 map to 'A'..'F'
   always_comb begin
      ascii = 8'h00;
      if (nib < 4'd10) begin
         ascii = 8'h30 + {4'h0, nib};
      end else begin
         ascii = 8'h37 + {4'h0, nib};
      end
   end

endmodule

module hex_tx_sequencer #(
   parameter int NIBBLES = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [4*NIBBLES-1:0] word_i,
   input  logic                 word_valid,
   output logic                 word_ready,
   output logic [7:0]           tx_data,
   output logic                 tx_valid,
   input  logic                 tx_ready,
   output logic                 busy
);

   localparam int W  = 4 * NIBBLES;
   localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(NIBBLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      SEND_NIB
`ifdef HEX_TX_SEQUENCER_CRLF_EN
      , SEND_CR
      , SEND_LF
`endif
   } state_t;

   state_t          state_reg;
   logic [W-1:0]    shift_reg;
   logic [W-1:0]    shift_next;
   logic [CW-1:0]   cnt_reg;
   logic [3:0]      conv_nib;
   logic [7:0]      conv_ascii;

   // Shift register as it will look after the current digit is consumed
   assign shift_next = shift_reg << 4;

   // tx_data is registered, so the converter looks one byte ahead: in IDLE it
   // sees the top nibble of the incoming word, otherwise the next nibble.
   always_comb begin
      conv_nib = shift_next[W-1 -: 4];
      if (state_reg == IDLE) begin
         conv_nib = word_i[W-1 -: 4];
      end
   end

   dec2assic u_conv (
      .nib   (conv_nib),
      .ascii (conv_ascii)
   );

   // Sequencer FSM with all handshake outputs registered
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= IDLE;
         shift_reg  <= '0;
         cnt_reg    <= '0;
         tx_data    <= 8'h00;
         tx_valid   <= 1'b0;
         word_ready <= 1'b1;
         busy       <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (word_valid) begin
                  shift_reg  <= word_i;
                  cnt_reg    <= CNT_LOAD;
                  tx_data    <= conv_ascii;
                  tx_valid   <= 1'b1;
                  word_ready <= 1'b0;
                  busy       <= 1'b1;
                  state_reg  <= SEND_NIB;
               end
            end
            SEND_NIB: begin
               if (tx_ready) begin
                  if (cnt_reg != '0) begin
                     shift_reg <= shift_next;
                     cnt_reg   <= cnt_reg - CW'(1);
                     tx_data   <= conv_ascii;
                  end else begin
`ifdef HEX_TX_SEQUENCER_CRLF_EN
                     tx_data   <= 8'h0D;
                     state_reg <= SEND_CR;
`else
                     tx_valid   <= 1'b0;
                     word_ready <= 1'b1;
                     busy       <= 1'b0;
                     state_reg  <= IDLE;
`endif
                  end
               end
            end
`ifdef HEX_TX_SEQUENCER_CRLF_EN
            SEND_CR: begin
               if (tx_ready) begin
                  tx_data   <= 8'h0A;
                  state_reg <= SEND_LF;
               end
            end
            SEND_LF: begin
               if (tx_ready) begin
                  tx_valid   <= 1'b0;
                  word_ready <= 1'b1;
                  busy       <= 1'b0;
                  state_reg  <= IDLE;
               end
            end
`endif
            default: begin
               tx_valid   <= 1'b0;
               word_ready <= 1'b1;
               busy       <= 1'b0;
               state_reg  <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hex_tx_sequencer.sv
// Testbench for hex_tx_sequencer: two instances (8 and 2 nibbles) driven by
// a shared task; expected byte streams come from a simple per-word model.
module tb_hex_tx_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] wbus = '0;
   logic        word_valid = 1'b0;
   logic        tx_ready = 1'b0;
   logic        sel = 1'b0;

   logic        rdy8, tv8, busy8, rdy2, tv2, busy2;
   logic [7:0]  d8, d2;
   logic        vld8, vld2;
   logic        o_rdy, o_tv, o_busy;
   logic [7:0]  o_data;

   int nchk = 0;
   int nfail = 0;

   always #5 clk = ~clk;

   assign vld8   = word_valid & ~sel;
   assign vld2   = word_valid & sel;
   assign o_rdy  = sel ? rdy2  : rdy8;
   assign o_tv   = sel ? tv2   : tv8;
   assign o_busy = sel ? busy2 : busy8;
   assign o_data = sel ? d2    : d8;

   hex_tx_sequencer #(.NIBBLES(8)) u8 (
      .clk(clk), .rst_n(rst_n), .word_i(wbus), .word_valid(vld8),
      .word_ready(rdy8), .tx_data(d8), .tx_valid(tv8), .tx_ready(tx_ready),
      .busy(busy8)
   );

   hex_tx_sequencer #(.NIBBLES(2)) u2 (
      .clk(clk), .rst_n(rst_n), .word_i(wbus[7:0]), .word_valid(vld2),
      .word_ready(rdy2), .tx_data(d2), .tx_valid(tv2), .tx_ready(tx_ready),
      .busy(busy2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Send one word on the selected DUT and check every byte cycle.
   // stall0: tx_ready-low cycles on the first byte; rnd: random stalls later;
   // hold: keep word_valid high with w_alt after accept; abort_at: byte index
   // at which reset is asserted (-1 = never).
   task automatic run_word(input bit s, input logic [31:0] w, input logic [31:0] w_alt,
                           input bit hold, input int stall0, input bit rnd, input int abort_at);
      logic [7:0] q[$];
      int n;
      int stalls;
      logic [3:0] nb;
      n = s ? 2 : 8;
      for (int i = n - 1; i >= 0; i--) begin
         nb = 4'((w >> (4 * i)) & 32'hF);
         q.push_back(nb < 4'd10 ? 8'h30 + 8'(nb) : 8'h41 + 8'(nb) - 8'd10);
      end
`ifdef HEX_TX_SEQUENCER_CRLF_EN
      q.push_back(8'h0D);
      q.push_back(8'h0A);
`endif
      sel = s;
      chk("ready_before_accept", o_rdy, 1);
      wbus = w;
      word_valid = 1'b1;
      @(posedge clk); #1;
      if (hold) wbus = w_alt;
      else word_valid = 1'b0;
      for (int k = 0; k < q.size(); k++) begin
         if (k == abort_at) begin
            #2 rst_n = 1'b0;
            #1;
            chk("rst_tx_valid", o_tv, 0);
            chk("rst_word_ready", o_rdy, 1);
            chk("rst_busy", o_busy, 0);
            chk("rst_tx_data", o_data, 0);
            word_valid = 1'b0;
            @(negedge clk) rst_n = 1'b1;
            @(posedge clk); #1;
            $display("word %h aborted by reset at byte %0d", w, k);
            return;
         end
         stalls = (k == 0) ? stall0 : (rnd ? int'($urandom_range(0, 2)) : 0);
         tx_ready = 1'b0;
         repeat (stalls) begin
            chk("stall_tx_valid", o_tv, 1);
            chk("stall_tx_data", o_data, 32'(q[k]));
            chk("stall_busy", o_busy, 1);
            @(posedge clk); #1;
         end
         tx_ready = 1'b1;
         chk("tx_valid", o_tv, 1);
         chk("tx_data", o_data, 32'(q[k]));
         chk("busy", o_busy, 1);
         chk("ready_low", o_rdy, 0);
         @(posedge clk); #1;
      end
      chk("end_word_ready", o_rdy, 1);
      chk("end_tx_valid", o_tv, 0);
      chk("end_busy", o_busy, 0);
      $display("word %h (%0d nibbles) sent, %0d bytes", w, n, q.size());
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("reset_word_ready8", rdy8, 1);
      chk("reset_tx_valid8", tv8, 0);
      chk("reset_tx_data8", d8, 0);
      chk("reset_busy8", busy8, 0);
      chk("reset_word_ready2", rdy2, 1);
      chk("reset_tx_valid2", tv2, 0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      // Back-to-back digits with tx_ready high
      run_word(0, 32'h1234ABCD, 32'h0, 0, 0, 0, -1);
      // Small instance, busy exactly for its byte count
      run_word(1, 32'h000000F0, 32'h0, 0, 0, 0, -1);
      // Backpressure on the first byte
      run_word(0, 32'h00000009, 32'h0, 0, 5, 0, -1);
      // word_valid held with a different word while busy
      run_word(0, 32'hCAFEF00D, 32'h5A5A1234, 1, 0, 0, -1);
      run_word(0, 32'h5A5A1234, 32'h0, 0, 0, 0, -1);
      // Reset during the 4th byte, then a fresh word
      run_word(0, 32'hDEADBEEF, 32'h0, 0, 0, 0, 3);
      run_word(0, 32'h00000001, 32'h0, 0, 0, 0, -1);

      // Random words and stalls on both instances
      for (int i = 0; i < 12; i++) begin
         run_word(1'(i % 3 == 0), $urandom, 32'h0, 0, int'($urandom_range(0, 3)), 1, -1);
         repeat (int'($urandom_range(0, 2))) @(posedge clk);
         #0;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end

endmodule
